// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock.
// Valid/ready on both sides, optional two's-complement input, decimal overflow flag.
module bin_bcd_seq #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [BIN_W-1:0] bin_sr;
  logic [BIN_W-1:0] bin_shift;
  logic [BIN_W-1:0] load_mag;
  logic             load_neg;
  logic [BCD_W-1:0] bcd_acc;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic             last_bit;
  logic             ovf_acc;
  logic             neg_acc;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  // Operand conditioning: negative inputs are converted as their magnitude.
  // The most negative value maps to 2^(BIN_W-1), which still fits unsigned.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    load_neg = 1'b0;
    load_mag = in_bin;
    if (SIGNED != 0 && in_bin[BIN_W-1]) begin
      load_neg = 1'b1;
      load_mag = -in_bin;
    end
  end

  // Add-3 on every digit that is 5 or more; digits are independent 4-bit adds.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign bcd_adj[4*g +: 4] = (bcd_acc[4*g +: 4] >= 4'd5) ? bcd_acc[4*g +: 4] + 4'd3
                                                             : bcd_acc[4*g +: 4];
  end

  // Adjust and shift in the same cycle; the bit leaving the top digit feeds overflow.
  assign {last_bit, bcd_shift, bin_shift} = {bcd_adj, bin_sr, 1'b0};

  assign cnt_last = (cnt == LAST_CNT);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid)  next_state = CONV;
      CONV:    if (cnt_last)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      ovf_acc <= 1'b0;
      neg_acc <= 1'b0;
      cnt     <= '0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr  <= load_mag;
            neg_acc <= load_neg;
            bcd_acc <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end
        end
        CONV: begin
          bin_sr  <= bin_shift;
          bcd_acc <= bcd_shift;
          ovf_acc <= ovf_acc | last_bit;
          if (cnt_last) begin
            // Counter parks at its last value so it cannot wrap for power-of-two widths.
            out_bcd <= bcd_shift;
            out_ovf <= ovf_acc | last_bit;
            out_neg <= neg_acc;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
